// File: rtl/light_seq_ctrl.sv
// light_seq_ctrl: drives lightSelector sel/button so the RGB output steps
// through NUM_STEPS colours, one advance pulse every DWELL clocks, then
// freezes on the last colour until restarted or released to white.
module light_seq_ctrl #(
   parameter int unsigned DWELL     = 4,
   parameter int unsigned NUM_STEPS = 6,
   parameter int unsigned CNT_W     = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   output logic       sel,
   output logic       button,
   output logic       busy,
   output logic       done,
   output logic [2:0] step_cnt
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_HOLD
   } state_t;

   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
   localparam logic [2:0]       STEPS_END  = 3'(NUM_STEPS);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_dwell;
   logic [CNT_W-1:0] w_dwell_nxt;
   logic [2:0]       w_step_nxt;
   logic [2:0]       w_step_inc;
   logic             w_sel_nxt;
   logic             w_button_nxt;
   logic             w_busy_nxt;
   logic             w_done_nxt;

   assign w_step_inc = step_cnt + 3'd1;

   // State, dwell counter and all outputs are registered together.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_dwell  <= '0;
         sel      <= 1'b0;
         button   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         step_cnt <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_dwell  <= w_dwell_nxt;
         sel      <= w_sel_nxt;
         button   <= w_button_nxt;
         busy     <= w_busy_nxt;
         done     <= w_done_nxt;
         step_cnt <= w_step_nxt;
      end
   end

   // Next state and next output values; stop takes priority over start
   // and over a due advance pulse.
   always_comb begin
      w_state_nxt  = r_state;
      w_dwell_nxt  = r_dwell;
      w_step_nxt   = step_cnt;
      w_sel_nxt    = sel;
      w_button_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
      w_done_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_sel_nxt = 1'b0;
            if (start && !stop) begin
               w_state_nxt = S_RUN;
               w_dwell_nxt = '0;
               w_step_nxt  = '0;
               w_sel_nxt   = 1'b1;
               w_busy_nxt  = 1'b1;
            end
         end
         S_RUN: begin
            w_sel_nxt = 1'b1;
            if (stop) begin
               w_state_nxt = S_HOLD;
               w_dwell_nxt = '0;
            end else if (r_dwell == DWELL_LAST) begin
               w_button_nxt = 1'b1;
               w_dwell_nxt  = '0;
               w_step_nxt   = w_step_inc;
               if (w_step_inc == STEPS_END) begin
                  w_state_nxt = S_HOLD;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_busy_nxt = 1'b1;
               end
            end else begin
               w_dwell_nxt = r_dwell + 1'b1;
               w_busy_nxt  = 1'b1;
            end
         end
         S_HOLD: begin
            w_sel_nxt = 1'b1;
            if (stop) begin
               w_state_nxt = S_IDLE;
               w_sel_nxt   = 1'b0;
            end else if (start) begin
               w_state_nxt = S_RUN;
               w_dwell_nxt = '0;
               w_step_nxt  = '0;
               w_busy_nxt  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_sel_nxt   = 1'b0;
         end
      endcase
   end

endmodule
